// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus bundle: address handoff, I-cache port, decode port.
interface instr_fetch_stage_if #(
  parameter int WORD_LENGTH = 32
);
  logic                   inAdrValid;
  logic [WORD_LENGTH-1:0] inPstate0;
  logic [WORD_LENGTH-1:0] inPstate1;
  logic                   outAdrReady;
  logic                   inFlush;
  logic                   outIcReqValid;
  logic [WORD_LENGTH-1:0] outIcSeg;
  logic [WORD_LENGTH-1:0] outIcOfs;
  logic                   inIcReqReady;
  logic                   inIcRspValid;
  logic [WORD_LENGTH-1:0] inIcRspData;
  logic                   inIcRspErr;
  logic                   outInstrValid;
  logic [WORD_LENGTH-1:0] outInstr;
  logic [WORD_LENGTH-1:0] outPstate0;
  logic [WORD_LENGTH-1:0] outPstate1;
  logic                   outInstrErr;
  logic                   inDecReady;

  modport master (
    input  inAdrValid, inPstate0, inPstate1, inFlush,
    input  inIcReqReady, inIcRspValid, inIcRspData,
    input  inIcRspErr, inDecReady,
    output outAdrReady, outIcReqValid, outIcSeg, outIcOfs,
    output outInstrValid, outInstr, outPstate0, outPstate1,
    output outInstrErr
  );

  modport slave (
    output inAdrValid, inPstate0, inPstate1, inFlush,
    output inIcReqReady, inIcRspValid, inIcRspData,
    output inIcRspErr, inDecReady,
    input  outAdrReady, outIcReqValid, outIcSeg, outIcOfs,
    input  outInstrValid, outInstr, outPstate0, outPstate1,
    input  outInstrErr
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: in-order fetch buffer with flush drain.
// IFETCH_PERF_CNT_EN adds fetch/stall performance counters.
module instr_fetch_stage #(
  parameter int WORD_LENGTH = 32,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic clk,
  input  logic rst,
  instr_fetch_stage_if.master bus
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] outFetchCnt,
  output logic [31:0] outStallCnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef logic [WORD_LENGTH-1:0] word_t;
  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t state, state_nx;

  word_t             ps0_q [FIFO_DEPTH];
  word_t             ps1_q [FIFO_DEPTH];
  word_t             instr_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] used, filled, err;

  logic [AW-1:0] alloc_ptr, rd_ptr, fill_ptr, idx;
  logic [CW-1:0] count, outstanding, drop_cnt, drop_nx;
  word_t         req_ps0, req_ps1;

  logic adr_ready, req_valid, accept, issue, mis_alloc;
  logic head_valid, pop, rsp_take, fill, misalign, found;

  assign misalign   = |bus.inPstate1[1:0];
  assign head_valid = used[rd_ptr] & filled[rd_ptr];
  assign pop        = head_valid & bus.inDecReady;
  assign rsp_take   = bus.inIcRspValid && outstanding != '0;
  assign fill       = rsp_take && !bus.inFlush;

  // Oldest allocated-but-unfilled entry; misaligned entries are skipped.
  always_comb begin
    fill_ptr = rd_ptr;
    found    = 1'b0;
    idx      = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      idx = rd_ptr + AW'(i);
      if (!found && used[idx] && !filled[idx]) begin
        fill_ptr = idx;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    adr_ready = 1'b0;
    req_valid = 1'b0;
    accept    = 1'b0;
    issue     = 1'b0;
    mis_alloc = 1'b0;
    drop_nx   = drop_cnt;
    unique case (state)
      IDLE: begin
        adr_ready = !rst && !bus.inFlush &&
                    count < CW'(FIFO_DEPTH);
        accept    = adr_ready && bus.inAdrValid;
        mis_alloc = accept && misalign;
        if (accept && !misalign) state_nx = REQ;
      end
      REQ: begin
        req_valid = 1'b1;
        if (bus.inIcReqReady) begin
          issue    = 1'b1;
          state_nx = IDLE;
        end
      end
      DRAIN: begin
        if (bus.inIcRspValid) begin
          drop_nx = drop_cnt - CW'(1);
          if (drop_cnt == CW'(1)) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A request the cache takes in the flush cycle still returns a word.
    if (bus.inFlush && state != DRAIN) begin
      drop_nx  = outstanding - CW'(rsp_take) + CW'(issue);
      state_nx = (drop_nx != '0) ? DRAIN : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      used        <= '0;
      filled      <= '0;
      err         <= '0;
      alloc_ptr   <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      req_ps0     <= '0;
      req_ps1     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ps0_q[i]   <= '0;
        ps1_q[i]   <= '0;
        instr_q[i] <= '0;
      end
    end else if (bus.inFlush) begin
      used        <= '0;
      filled      <= '0;
      alloc_ptr   <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= drop_nx;
    end else begin
      drop_cnt <= drop_nx;
      if (accept && !misalign) begin
        req_ps0 <= bus.inPstate0;
        req_ps1 <= bus.inPstate1;
      end
      if (issue || mis_alloc) begin
        used[alloc_ptr]    <= 1'b1;
        filled[alloc_ptr]  <= mis_alloc;
        err[alloc_ptr]     <= mis_alloc;
        instr_q[alloc_ptr] <= '0;
        ps0_q[alloc_ptr]   <= issue ? req_ps0 : bus.inPstate0;
        ps1_q[alloc_ptr]   <= issue ? req_ps1 : bus.inPstate1;
        alloc_ptr          <= alloc_ptr + AW'(1);
      end
      if (fill) begin
        filled[fill_ptr]  <= 1'b1;
        err[fill_ptr]     <= bus.inIcRspErr;
        instr_q[fill_ptr] <= bus.inIcRspData;
      end
      if (pop) begin
        used[rd_ptr]   <= 1'b0;
        filled[rd_ptr] <= 1'b0;
        rd_ptr         <= rd_ptr + AW'(1);
      end
      count       <= count + CW'(issue | mis_alloc) - CW'(pop);
      outstanding <= outstanding + CW'(issue) - CW'(fill);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(bus.inIcRspValid && outstanding == '0
                && drop_cnt == '0));
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      outFetchCnt <= '0;
      outStallCnt <= '0;
    end else begin
      if (pop) outFetchCnt <= outFetchCnt + 32'd1;
      if (bus.inDecReady && !head_valid)
        outStallCnt <= outStallCnt + 32'd1;
    end
  end
`endif

  assign bus.outAdrReady   = adr_ready;
  assign bus.outIcReqValid = req_valid;
  assign bus.outIcSeg      = req_ps0;
  assign bus.outIcOfs      = req_ps1;
  assign bus.outInstrValid = head_valid;
  assign bus.outInstr      = instr_q[rd_ptr];
  assign bus.outPstate0    = ps0_q[rd_ptr];
  assign bus.outPstate1    = ps1_q[rd_ptr];
  assign bus.outInstrErr   = err[rd_ptr];
endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed scenarios plus random traffic
// against a queue-based model of the fetch buffer and I-cache.
module tb_instr_fetch_stage;
  localparam int W = 32;
  localparam int D = 4;

  typedef struct {
    logic [31:0] ps0;
    logic [31:0] ps1;
    logic [31:0] instr;
    bit          err;
    bit          filled;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_stage_if #(.WORD_LENGTH(W)) bus ();

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  instr_fetch_stage #(.WORD_LENGTH(W), .FIFO_DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .outFetchCnt(fetch_cnt),
    .outStallCnt(stall_cnt)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               tag, $time, got, exp);
    end
  endtask

  // stimulus knobs
  bit          a_valid, flush, req_rdy, dec_rdy, rsp_en, err_next;
  logic [31:0] a_ps0, a_ps1, rsp_word;

  // reference model
  ent_t        q[$];
  bit          m_pend, accepted;
  logic [31:0] m_seg, m_ofs, m_fcnt, m_scnt;
  int          m_drop, ic_pend;

  task automatic cycle();
    bit e_ardy, e_req, e_vld, rsp, done;
    int unf;
    @(negedge clk);
    bus.inAdrValid   = a_valid;
    bus.inPstate0    = a_ps0;
    bus.inPstate1    = a_ps1;
    bus.inFlush      = flush;
    bus.inIcReqReady = req_rdy;
    bus.inDecReady   = dec_rdy;
    rsp = rsp_en && ic_pend > 0 && !rst;
    bus.inIcRspValid = rsp;
    bus.inIcRspData  = rsp_word;
    bus.inIcRspErr   = rsp && err_next;
    #1;
    e_ardy = !rst && !m_pend && m_drop == 0 && !flush &&
             q.size() < D;
    e_req  = m_pend;
    e_vld  = q.size() > 0 && q[0].filled;
    check("adr_ready", bus.outAdrReady, e_ardy);
    check("ic_req_valid", bus.outIcReqValid, e_req);
    if (e_req) begin
      check("ic_seg", bus.outIcSeg, m_seg);
      check("ic_ofs", bus.outIcOfs, m_ofs);
    end
    check("instr_valid", bus.outInstrValid, e_vld);
    if (e_vld) begin
      check("instr", bus.outInstr, q[0].instr);
      check("pstate0", bus.outPstate0, q[0].ps0);
      check("pstate1", bus.outPstate1, q[0].ps1);
      check("instr_err", bus.outInstrErr, q[0].err);
    end
`ifdef IFETCH_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, m_fcnt);
    check("stall_cnt", stall_cnt, m_scnt);
`endif
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_pend  = 0;
      m_drop  = 0;
      ic_pend = 0;
      m_fcnt  = 0;
      m_scnt  = 0;
    end else begin
      unf = 0;
      foreach (q[i]) if (!q[i].filled) unf++;
      if (e_vld && dec_rdy) m_fcnt++;
      if (dec_rdy && !e_vld) m_scnt++;
      if (rsp) ic_pend--;
      if (e_req && req_rdy) ic_pend++;
      if (flush) begin
        if (m_drop > 0) begin
          if (rsp) m_drop--;
        end else begin
          m_drop = unf - int'(rsp) + int'(e_req && req_rdy);
        end
        q.delete();
        m_pend = 0;
      end else begin
        if (e_vld && dec_rdy) void'(q.pop_front());
        if (rsp) begin
          if (m_drop > 0) m_drop--;
          else begin
            done = 0;
            foreach (q[i])
              if (!done && !q[i].filled) begin
                q[i].filled = 1;
                q[i].instr  = rsp_word;
                q[i].err    = err_next;
                done        = 1;
              end
          end
        end
        if (e_req && req_rdy) begin
          q.push_back('{m_seg, m_ofs, 32'h0, 1'b0, 1'b0});
          m_pend = 0;
        end else if (e_ardy && a_valid) begin
          accepted = 1;
          if (a_ps1[1:0] != 2'b00)
            q.push_back('{a_ps0, a_ps1, 32'h0, 1'b1, 1'b1});
          else begin
            m_pend = 1;
            m_seg  = a_ps0;
            m_ofs  = a_ps1;
          end
        end
      end
    end
  endtask

  task automatic idle(int n);
    a_valid = 0;
    repeat (n) cycle();
  endtask

  task automatic fetch(logic [31:0] p0, logic [31:0] p1);
    accepted = 0;
    a_valid  = 1;
    a_ps0    = p0;
    a_ps1    = p1;
    for (int i = 0; i < 30 && !accepted; i++) cycle();
    check("fetch_accept", 32'(accepted), 32'd1);
    a_valid = 0;
  endtask

  initial begin
    a_valid = 0; flush = 0; req_rdy = 0; dec_rdy = 0;
    rsp_en = 0; err_next = 0; a_ps0 = 0; a_ps1 = 0;
    rsp_word = 0; m_pend = 0; m_drop = 0; ic_pend = 0;
    m_fcnt = 0; m_scnt = 0; m_seg = 0; m_ofs = 0;
    accepted = 0;

    repeat (3) cycle();
    check("rst_instr", bus.outInstr, 32'h0);
    check("rst_ps0", bus.outPstate0, 32'h0);
    check("rst_ps1", bus.outPstate1, 32'h0);
    check("rst_err", bus.outInstrErr, 32'h0);
    check("rst_seg", bus.outIcSeg, 32'h0);
    check("rst_ofs", bus.outIcOfs, 32'h0);
    rst = 0;

    // basic fetch
    req_rdy = 1; dec_rdy = 1; rsp_word = 32'hDEADBEEF;
    fetch(32'h0, 32'h100);
    idle(2);
    rsp_en = 1; cycle(); rsp_en = 0;
    idle(3);

    // fill the buffer with decode stalled, then wrap
    dec_rdy = 0; rsp_en = 1;
    for (int i = 0; i < 4; i++) begin
      rsp_word = 32'hA000_0000 + 32'(i);
      fetch(32'(i), 32'h200 + 32'(4 * i));
    end
    idle(4);
    dec_rdy = 1; cycle(); dec_rdy = 0;
    rsp_word = 32'hA000_0009;
    fetch(32'h9, 32'h300);
    idle(3);
    dec_rdy = 1;
    idle(8);

    // flush with three fetches in flight
    rsp_en = 0;
    for (int i = 0; i < 3; i++) fetch(32'h7, 32'h340 + 32'(4 * i));
    idle(1);
    flush = 1; cycle(); flush = 0;
    rsp_en = 1; rsp_word = 32'hBAD0_0000;
    idle(6);
    rsp_word = 32'h1234_5678;
    fetch(32'h0, 32'h400);
    idle(5);

    // misaligned offset
    fetch(32'h3, 32'h102);
    idle(3);

    // fault on second of two fetches
    rsp_en = 0;
    fetch(32'h1, 32'h500);
    fetch(32'h1, 32'h504);
    idle(1);
    rsp_en = 1; err_next = 0; rsp_word = 32'h1111_1111; cycle();
    err_next = 1; rsp_word = 32'h2222_2222; cycle();
    err_next = 0; rsp_en = 0;
    idle(3);

    // flush and address offered together
    a_valid = 1; a_ps0 = 32'h5; a_ps1 = 32'h600;
    flush = 1; cycle(); flush = 0;
    idle(2);

    // random traffic
    repeat (3000) begin
      a_valid  = $urandom_range(0, 2) != 0;
      a_ps0    = $urandom;
      a_ps1    = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0)
        a_ps1[1:0] = 2'($urandom_range(1, 3));
      req_rdy  = $urandom_range(0, 3) != 0;
      rsp_en   = $urandom_range(0, 2) != 0;
      err_next = $urandom_range(0, 9) == 0;
      rsp_word = $urandom;
      dec_rdy  = $urandom_range(0, 3) != 0;
      flush    = $urandom_range(0, 40) == 0;
      cycle();
    end
    a_valid = 0; flush = 0; rsp_en = 1; dec_rdy = 1;
    idle(20);

    // reset clears the counters
    rst = 1;
    idle(2);
`ifdef IFETCH_PERF_CNT_EN
    check("rst_fetch_cnt", fetch_cnt, 32'h0);
    check("rst_stall_cnt", stall_cnt, 32'h0);
`endif
    rst = 0;
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
